// File: rtl/node_injector_if.sv
// Node-side local link of a mesh router: packet request, payload stream and flit output
// with per-VC on/off and allocatable status.
interface node_injector_if #(
  parameter int unsigned MAX_PKT_LEN      = 8,
  parameter int unsigned VC_NUM           = 2,
  parameter int unsigned DEST_ADDR_SIZE_X = 2,
  parameter int unsigned DEST_ADDR_SIZE_Y = 2,
  parameter int unsigned PAYLOAD_W        = 16
);
  localparam int unsigned LenW  = $clog2(MAX_PKT_LEN + 1);
  localparam int unsigned VcW   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned FlitW = 2 + VcW + PAYLOAD_W;

  logic                        req_valid_i;
  logic                        req_ready_o;
  logic [DEST_ADDR_SIZE_X-1:0] req_x_dest_i;
  logic [DEST_ADDR_SIZE_Y-1:0] req_y_dest_i;
  logic [LenW-1:0]             req_len_i;
  logic                        pl_valid_i;
  logic                        pl_ready_o;
  logic [PAYLOAD_W-1:0]        pl_data_i;
  logic [FlitW-1:0]            data_o;
  logic                        is_valid_o;
  logic [VC_NUM-1:0]           is_on_off_i;
  logic [VC_NUM-1:0]           is_allocatable_i;

  modport master (
    output req_valid_i, req_x_dest_i, req_y_dest_i, req_len_i,
    output pl_valid_i, pl_data_i, is_on_off_i, is_allocatable_i,
    input  req_ready_o, pl_ready_o, data_o, is_valid_o
  );

  modport slave (
    input  req_valid_i, req_x_dest_i, req_y_dest_i, req_len_i,
    input  pl_valid_i, pl_data_i, is_on_off_i, is_allocatable_i,
    output req_ready_o, pl_ready_o, data_o, is_valid_o
  );
endinterface

// File: rtl/node_injector.sv
// Packetizes (dest, len) requests plus a payload stream into HEAD/BODY/TAIL/HEADTAIL flits
// on a round-robin selected virtual channel. Flit = {label[1:0], vc_id, payload}.
module node_injector #(
  parameter int unsigned MAX_PKT_LEN      = 8,
  parameter int unsigned VC_NUM           = 2,
  parameter int unsigned DEST_ADDR_SIZE_X = 2,
  parameter int unsigned DEST_ADDR_SIZE_Y = 2,
  parameter int unsigned PAYLOAD_W        = 16,
  parameter int unsigned X_CURRENT        = 0,
  parameter int unsigned Y_CURRENT        = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  node_injector_if.slave              bus,
  output logic                        busy_o,
  output logic                        err_len_o,
  output logic [DEST_ADDR_SIZE_X-1:0] src_x_o,
  output logic [DEST_ADDR_SIZE_Y-1:0] src_y_o
);
  localparam int unsigned LenW  = $clog2(MAX_PKT_LEN + 1);
  localparam int unsigned VcW   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned FlitW = 2 + VcW + PAYLOAD_W;

  typedef enum logic [1:0] {
    LblHead     = 2'b00,
    LblBody     = 2'b01,
    LblTail     = 2'b10,
    LblHeadTail = 2'b11
  } flit_label_e;

  typedef enum logic [1:0] {StIdle, StVcSel, StSendHead, StSendBody} state_e;

  state_e                      r_state, w_state_next;
  logic [DEST_ADDR_SIZE_X-1:0] r_x, w_x_next;
  logic [DEST_ADDR_SIZE_Y-1:0] r_y, w_y_next;
  logic [LenW-1:0]             r_len, w_len_next;
  logic [LenW-1:0]             r_rem, w_rem_next;
  logic [VcW-1:0]              r_vc, w_vc_next;
  logic [VcW-1:0]              r_rr, w_rr_next;
  logic                        r_valid, w_valid_next;
  logic [FlitW-1:0]            r_data, w_data_next;
  logic                        r_err, w_err_next;

  logic                        w_found;
  logic [VcW-1:0]              w_pick;
  logic [VcW:0]                w_sum;
  logic [VcW:0]                w_rr_inc;
  logic                        w_len_ok;
  logic                        w_vc_on;

  // First VC at or after the rr pointer that is both free and switched on.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int unsigned i = 0; i < VC_NUM; i++) begin
      w_sum = {1'b0, r_rr} + (VcW + 1)'(i);
      if (w_sum >= (VcW + 1)'(VC_NUM)) w_sum = w_sum - (VcW + 1)'(VC_NUM);
      if (!w_found && bus.is_allocatable_i[w_sum[VcW-1:0]] &&
          bus.is_on_off_i[w_sum[VcW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[VcW-1:0];
      end
    end
    w_rr_inc = {1'b0, w_pick} + (VcW + 1)'(1);
    if (w_rr_inc >= (VcW + 1)'(VC_NUM)) w_rr_inc = w_rr_inc - (VcW + 1)'(VC_NUM);
  end

  assign w_len_ok = (bus.req_len_i != '0) && (bus.req_len_i <= LenW'(MAX_PKT_LEN));
  assign w_vc_on  = bus.is_on_off_i[r_vc];

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_len_next   = r_len;
    w_rem_next   = r_rem;
    w_vc_next    = r_vc;
    w_rr_next    = r_rr;
    w_valid_next = 1'b0;
    w_data_next  = r_data;
    w_err_next   = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.req_valid_i) begin
          if (w_len_ok) begin
            w_x_next     = bus.req_x_dest_i;
            w_y_next     = bus.req_y_dest_i;
            w_len_next   = bus.req_len_i;
            w_state_next = StVcSel;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      StVcSel: begin
        if (w_found) begin
          w_vc_next    = w_pick;
          w_rr_next    = w_rr_inc[VcW-1:0];
          w_state_next = StSendHead;
        end
      end
      StSendHead: begin
        if (w_vc_on) begin
          w_valid_next = 1'b1;
          if (r_len == LenW'(1)) begin
            w_data_next  = {LblHeadTail, r_vc, PAYLOAD_W'({r_x, r_y})};
            w_state_next = StIdle;
          end else begin
            w_data_next  = {LblHead, r_vc, PAYLOAD_W'({r_x, r_y})};
            w_rem_next   = r_len - LenW'(1);
            w_state_next = StSendBody;
          end
        end
      end
      StSendBody: begin
        if (bus.pl_valid_i && w_vc_on) begin
          w_valid_next = 1'b1;
          w_rem_next   = r_rem - LenW'(1);
          if (r_rem == LenW'(1)) begin
            w_data_next  = {LblTail, r_vc, bus.pl_data_i};
            w_state_next = StIdle;
          end else begin
            w_data_next = {LblBody, r_vc, bus.pl_data_i};
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_y     <= '0;
      r_len   <= '0;
      r_rem   <= '0;
      r_vc    <= '0;
      r_rr    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_len   <= w_len_next;
      r_rem   <= w_rem_next;
      r_vc    <= w_vc_next;
      r_rr    <= w_rr_next;
      r_valid <= w_valid_next;
      r_data  <= w_data_next;
      r_err   <= w_err_next;
    end
  end

  // Ready is gated by rst so the request port reads not-ready while held in reset.
  assign bus.req_ready_o = (r_state == StIdle) && !rst;
  assign bus.pl_ready_o  = (r_state == StSendBody) && w_vc_on;
  assign bus.data_o      = r_data;
  assign bus.is_valid_o  = r_valid;
  assign busy_o          = (r_state != StIdle);
  assign err_len_o       = r_err;
  assign src_x_o         = DEST_ADDR_SIZE_X'(X_CURRENT);
  assign src_y_o         = DEST_ADDR_SIZE_Y'(Y_CURRENT);
endmodule

// File: tb/tb_node_injector.sv
// Scoreboard bench for node_injector: expected flits are queued as stimulus is issued and
// checked in order as the router-side link presents them.
module tb_node_injector;
  localparam int unsigned MaxLen = 8;
  localparam int unsigned VcNum  = 2;
  localparam int unsigned Dx     = 2;
  localparam int unsigned Dy     = 2;
  localparam int unsigned Pw     = 16;
  localparam int unsigned FlitW  = 2 + 1 + Pw;
  localparam logic [1:0]  LHead  = 2'b00;
  localparam logic [1:0]  LBody  = 2'b01;
  localparam logic [1:0]  LTail  = 2'b10;
  localparam logic [1:0]  LHt    = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic          err_len;
  logic [Dx-1:0] src_x;
  logic [Dy-1:0] src_y;

  int n_checks = 0;
  int n_fail   = 0;
  int n_flits  = 0;
  int pl_rdy_cnt = 0;
  int cyc = 0;
  int flit_cyc[$];
  logic [FlitW-1:0] exp_q[$];
  logic [FlitW-1:0] mon_exp;
  logic [Pw-1:0]    pl_q[$];
  logic             pl_hs;

  node_injector_if #(
    .MAX_PKT_LEN(MaxLen), .VC_NUM(VcNum), .DEST_ADDR_SIZE_X(Dx), .DEST_ADDR_SIZE_Y(Dy),
    .PAYLOAD_W(Pw)
  ) bif ();

  node_injector #(
    .MAX_PKT_LEN(MaxLen), .VC_NUM(VcNum), .DEST_ADDR_SIZE_X(Dx), .DEST_ADDR_SIZE_Y(Dy),
    .PAYLOAD_W(Pw), .X_CURRENT(1), .Y_CURRENT(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bif), .busy_o(busy), .err_len_o(err_len),
    .src_x_o(src_x), .src_y_o(src_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FlitW-1:0] mk(input logic [1:0] lbl, input logic vc,
                                          input logic [Pw-1:0] d);
    return {lbl, vc, d};
  endfunction

  function automatic logic [FlitW-1:0] hd(input logic [Dx-1:0] x, input logic [Dy-1:0] y,
                                          input int len, input logic vc);
    return mk((len == 1) ? LHt : LHead, vc, Pw'({x, y}));
  endfunction

  // Monitor: every valid flit must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bif.is_valid_o) begin
      n_flits++;
      flit_cyc.push_back(cyc);
      check_eq("flit_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check_eq("flit", 32'(bif.data_o), 32'(mon_exp));
      end
    end
    if (bif.pl_ready_o) pl_rdy_cnt++;
  end

  // Payload source: presents the head of pl_q, advances after each handshake.
  always begin
    @(posedge clk);
    pl_hs = bif.pl_valid_i && bif.pl_ready_o;
    #1;
    if (pl_hs && pl_q.size() > 0) void'(pl_q.pop_front());
    bif.pl_valid_i = (pl_q.size() > 0);
    bif.pl_data_i  = (pl_q.size() > 0) ? pl_q[0] : '0;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    pl_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_flits = 0;
    pl_rdy_cnt = 0;
    flit_cyc.delete();
  endtask

  task automatic do_req(input logic [Dx-1:0] x, input logic [Dy-1:0] y, input logic [3:0] len);
    int t;
    @(negedge clk);
    bif.req_x_dest_i = x;
    bif.req_y_dest_i = y;
    bif.req_len_i    = len;
    bif.req_valid_i  = 1'b1;
    t = 0;
    while (!bif.req_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("req_ready", 32'(bif.req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    bif.req_valid_i = 1'b0;
  endtask

  task automatic wait_flits(input int n);
    for (int i = 0; i < 100 && n_flits < n; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("flit_count", 32'(n_flits), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    rst = 1'b1;
    bif.req_valid_i = 1'b0;
    bif.req_x_dest_i = '0;
    bif.req_y_dest_i = '0;
    bif.req_len_i = '0;
    bif.pl_valid_i = 1'b0;
    bif.pl_data_i = '0;
    bif.is_on_off_i = 2'b11;
    bif.is_allocatable_i = 2'b11;
    #1;
    check_eq("rst_valid", 32'(bif.is_valid_o), 32'd0);
    check_eq("rst_data", 32'(bif.data_o), 32'd0);
    check_eq("rst_req_ready", 32'(bif.req_ready_o), 32'd0);
    check_eq("rst_pl_ready", 32'(bif.pl_ready_o), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err_len), 32'd0);
    check_eq("src_xy", 32'({src_x, src_y}), 32'h6);

    // Three-flit packet on consecutive cycles.
    do_reset();
    pl_q.push_back(16'h000A);
    pl_q.push_back(16'h000B);
    exp_q.push_back(hd(2'd2, 2'd3, 3, 1'b0));
    exp_q.push_back(mk(LBody, 1'b0, 16'h000A));
    exp_q.push_back(mk(LTail, 1'b0, 16'h000B));
    do_req(2'd2, 2'd3, 4'd3);
    wait_flits(3);
    if (flit_cyc.size() == 3) begin
      check_eq("t1_gap_hb", 32'(flit_cyc[1] - flit_cyc[0]), 32'd1);
      check_eq("t1_gap_bt", 32'(flit_cyc[2] - flit_cyc[1]), 32'd1);
    end
    check_eq("t1_busy_after_tail", 32'(busy), 32'd0);
    check_eq("t1_req_ready_idle", 32'(bif.req_ready_o), 32'd1);

    // Two single-flit packets alternate VCs.
    do_reset();
    exp_q.push_back(hd(2'd1, 2'd1, 1, 1'b0));
    do_req(2'd1, 2'd1, 4'd1);
    exp_q.push_back(hd(2'd3, 2'd0, 1, 1'b1));
    do_req(2'd3, 2'd0, 4'd1);
    wait_flits(2);
    check_eq("t2_pl_ready_cycles", 32'(pl_rdy_cnt), 32'd0);

    // VC0 switched off for 4 cycles mid-body.
    do_reset();
    pl_q.push_back(16'h0011);
    pl_q.push_back(16'h0022);
    pl_q.push_back(16'h0033);
    exp_q.push_back(hd(2'd0, 2'd2, 4, 1'b0));
    exp_q.push_back(mk(LBody, 1'b0, 16'h0011));
    exp_q.push_back(mk(LBody, 1'b0, 16'h0022));
    exp_q.push_back(mk(LTail, 1'b0, 16'h0033));
    do_req(2'd0, 2'd2, 4'd4);
    wait_flits(2);
    bif.is_on_off_i = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_eq("t3_off_valid", 32'(bif.is_valid_o), 32'd0);
      check_eq("t3_off_pl_ready", 32'(bif.pl_ready_o), 32'd0);
    end
    bif.is_on_off_i = 2'b11;
    wait_flits(4);
    if (flit_cyc.size() == 4) check_eq("t3_resume_gap", 32'(flit_cyc[2] - flit_cyc[1]), 32'd5);

    // No allocatable VC for 5 cycles, then only vc1 frees up.
    do_reset();
    bif.is_allocatable_i = 2'b00;
    exp_q.push_back(hd(2'd0, 2'd1, 1, 1'b1));
    do_req(2'd0, 2'd1, 4'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check_eq("t4_blocked_valid", 32'(bif.is_valid_o), 32'd0);
      check_eq("t4_blocked_busy", 32'(busy), 32'd1);
    end
    bif.is_allocatable_i = 2'b10;
    c0 = cyc;
    wait_flits(1);
    if (flit_cyc.size() == 1) check_eq("t4_head_latency", 32'(flit_cyc[0] - c0), 32'd2);
    bif.is_allocatable_i = 2'b11;

    // Illegal lengths pulse err_len and emit nothing.
    do_reset();
    do_req(2'd1, 2'd1, 4'd0);
    check_eq("t5_err_len0", 32'(err_len), 32'd1);
    check_eq("t5_busy_len0", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t5_err_clear0", 32'(err_len), 32'd0);
    do_req(2'd1, 2'd1, 4'(MaxLen + 1));
    check_eq("t5_err_len9", 32'(err_len), 32'd1);
    @(posedge clk);
    #1;
    check_eq("t5_err_clear9", 32'(err_len), 32'd0);
    check_eq("t5_no_flits", 32'(n_flits), 32'd0);
    pl_q.push_back(16'h0077);
    exp_q.push_back(hd(2'd1, 2'd2, 2, 1'b0));
    exp_q.push_back(mk(LTail, 1'b0, 16'h0077));
    do_req(2'd1, 2'd2, 4'd2);
    wait_flits(2);

    // Reset right after the head of a 4-flit packet.
    do_reset();
    exp_q.push_back(hd(2'd3, 2'd3, 4, 1'b0));
    do_req(2'd3, 2'd3, 4'd4);
    wait_flits(1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(bif.is_valid_o), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_exp_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_flits = 0;
    flit_cyc.delete();
    pl_q.push_back(16'h005A);
    exp_q.push_back(hd(2'd2, 2'd1, 2, 1'b0));
    exp_q.push_back(mk(LTail, 1'b0, 16'h005A));
    do_req(2'd2, 2'd1, 4'd2);
    wait_flits(2);
    repeat (3) @(negedge clk);
    check_eq("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
